// File: rtl/lut_sweep_unit.sv
// Programmable N-input boolean function: a 2^N-bit truth table with a registered
// single-vector evaluate port and a sweep engine that streams every entry and counts ones.
module lut_sweep_unit #(
  parameter int unsigned         N    = 4,
  parameter logic [(2**N)-1:0]   INIT = 16'hAC3C
) (
  input  logic         clk,
  input  logic         rst,

  input  logic         cfg_we,
  input  logic [N-1:0] cfg_addr,
  input  logic         cfg_bit,

  input  logic         eval_valid,
  input  logic [N-1:0] eval_in,
  output logic         eval_out_valid,
  output logic         eval_out,

  input  logic         start,
  output logic         busy,
  output logic         sweep_valid,
  output logic [N-1:0] sweep_idx,
  output logic         sweep_val,
  output logic         done,
  output logic [N:0]   ones_count
);

  localparam int unsigned Entries = 2**N;
  localparam logic [N-1:0] LastIdx = {N{1'b1}};

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e             state_q, state_d;
  logic [Entries-1:0] table_q;
  logic [N-1:0]       idx_q;
  logic [N:0]         count_q;
  logic               eval_out_q;
  logic               eval_valid_q;

  logic in_idle;
  logic in_sweep;
  logic last_idx;
  logic start_accept;
  logic cfg_accept;
  logic cur_bit;

  assign in_idle      = (state_q == StIdle);
  assign in_sweep     = (state_q == StSweep);
  assign last_idx     = (idx_q == LastIdx);
  assign start_accept = in_idle & start;
  // The table is only writable while no sweep is running.
  assign cfg_accept   = in_idle & cfg_we;
  assign cur_bit      = table_q[idx_q];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StSweep;
      StSweep: if (last_idx) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; idx/val are forced to zero outside the sweep window.
  always_comb begin
    busy        = 1'b0;
    sweep_valid = 1'b0;
    sweep_idx   = '0;
    sweep_val   = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      StIdle: ;
      StSweep: begin
        busy        = 1'b1;
        sweep_valid = 1'b1;
        sweep_idx   = idx_q;
        sweep_val   = cur_bit;
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Truth table
  always_ff @(posedge clk) begin
    if (rst) begin
      table_q <= INIT;
    end else if (cfg_accept) begin
      table_q[cfg_addr] <= cfg_bit;
    end
  end

  // Sweep index and ones counter
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      count_q <= '0;
    end else if (start_accept) begin
      idx_q   <= '0;
      count_q <= '0;
    end else if (in_sweep) begin
      count_q <= count_q + {{N{1'b0}}, cur_bit};
      if (!last_idx) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // Evaluate port; reads the pre-write table, so a same-cycle cfg write is not seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      eval_out_q   <= 1'b0;
      eval_valid_q <= 1'b0;
    end else begin
      eval_valid_q <= eval_valid;
      if (eval_valid) begin
        eval_out_q <= table_q[eval_in];
      end
    end
  end

  assign eval_out_valid = eval_valid_q;
  assign eval_out       = eval_out_q;
  assign ones_count     = count_q;

endmodule

// File: tb/tb_lut_sweep_unit.sv
// Directed self-checking bench for lut_sweep_unit with N=4 and the default AC3C table.
module tb_lut_sweep_unit;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic       cfg_bit;
  logic       eval_valid;
  logic [3:0] eval_in;
  logic       eval_out_valid;
  logic       eval_out;
  logic       start;
  logic       busy;
  logic       sweep_valid;
  logic [3:0] sweep_idx;
  logic       sweep_val;
  logic       done;
  logic [4:0] ones_count;

  int checks;
  int failures;

  // Hand-expanded AC3C, index 0..15
  logic [15:0] init_tbl;

  lut_sweep_unit #(
    .N    (4),
    .INIT (16'hAC3C)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_bit        (cfg_bit),
    .eval_valid     (eval_valid),
    .eval_in        (eval_in),
    .eval_out_valid (eval_out_valid),
    .eval_out       (eval_out),
    .start          (start),
    .busy           (busy),
    .sweep_valid    (sweep_valid),
    .sweep_idx      (sweep_idx),
    .sweep_val      (sweep_val),
    .done           (done),
    .ones_count     (ones_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic val);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_bit  = val;
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Starts a sweep and checks the whole stream, the done cycle and the following idle cycle.
  // poke_at >= 0 pulses start and a cfg write (addr 0, bit 1) during that sweep index.
  task automatic run_sweep(input string name, input logic [15:0] tbl, input int exp_count,
                           input int poke_at, input bit poke_done);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (sweep_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
          sweep_idx !== 4'(i) || sweep_val !== tbl[i]) begin
        failures++;
        $display("FAIL %s stream[%0d]: valid=%b busy=%b done=%b idx=%0d val=%b, want 1 1 0 %0d %b",
                 name, i, sweep_valid, busy, done, sweep_idx, sweep_val, i, tbl[i]);
      end
      if (i == poke_at) begin
        start    = 1'b1;
        cfg_we   = 1'b1;
        cfg_addr = 4'd0;
        cfg_bit  = 1'b1;
      end else begin
        start  = 1'b0;
        cfg_we = 1'b0;
      end
      step();
    end
    start  = 1'b0;
    cfg_we = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || sweep_valid !== 1'b0 ||
        ones_count !== 5'(exp_count)) begin
      failures++;
      $display("FAIL %s done_cycle: done=%b busy=%b valid=%b count=%0d, want 1 1 0 %0d",
               name, done, busy, sweep_valid, ones_count, exp_count);
    end
    if (poke_done) start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sweep_valid !== 1'b0 ||
        ones_count !== 5'(exp_count)) begin
      failures++;
      $display("FAIL %s after_done: done=%b busy=%b valid=%b count=%0d, want 0 0 0 %0d",
               name, done, busy, sweep_valid, ones_count, exp_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (eval_out_valid !== 1'b0 || eval_out !== 1'b0 || busy !== 1'b0 ||
        sweep_valid !== 1'b0 || sweep_idx !== 4'd0 || sweep_val !== 1'b0 ||
        done !== 1'b0 || ones_count !== 5'd0) begin
      failures++;
      $display("FAIL reset_values: ev=%b eo=%b busy=%b sv=%b idx=%0d val=%b done=%b cnt=%0d, want all 0",
               eval_out_valid, eval_out, busy, sweep_valid, sweep_idx, sweep_val, done,
               ones_count);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_sweep_init();
    run_sweep("sweep_init", init_tbl, 8, -1, 1'b0);
  endtask

  task automatic test_eval_all();
    pulse_reset();
    eval_valid = 1'b1;
    eval_in    = 4'd0;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (eval_out_valid !== 1'b1 || eval_out !== init_tbl[i]) begin
        failures++;
        $display("FAIL eval_all[%0d]: valid=%b out=%b, want 1 %b",
                 i, eval_out_valid, eval_out, init_tbl[i]);
      end
      if (i < 15) eval_in = 4'(i + 1);
      else eval_valid = 1'b0;
    end
    step();
    checks++;
    if (eval_out_valid !== 1'b0 || eval_out !== 1'b1) begin
      failures++;
      $display("FAIL eval_hold: valid=%b out=%b, want 0 1", eval_out_valid, eval_out);
    end
  endtask

  task automatic test_cfg_writes();
    pulse_reset();
    cfg_write(4'd12, 1'b1);
    cfg_write(4'd2, 1'b0);
    run_sweep("sweep_edit", 16'hBC38, 8, -1, 1'b0);
    for (int i = 0; i < 16; i++) cfg_write(4'(i), 1'b0);
    run_sweep("sweep_zeros", 16'h0000, 0, -1, 1'b0);
    for (int i = 0; i < 16; i++) cfg_write(4'(i), 1'b1);
    run_sweep("sweep_ones", 16'hFFFF, 16, -1, 1'b0);
  endtask

  task automatic test_busy_ignore();
    pulse_reset();
    run_sweep("sweep_poke", init_tbl, 8, 5, 1'b1);
    eval_valid = 1'b1;
    eval_in    = 4'd0;
    step();
    eval_valid = 1'b0;
    checks++;
    if (eval_out_valid !== 1'b1 || eval_out !== 1'b0) begin
      failures++;
      $display("FAIL busy_cfg_ignored: valid=%b table0=%b, want 1 0", eval_out_valid, eval_out);
    end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    pulse_reset();
    cfg_write(4'd0, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    checks++;
    if (sweep_valid !== 1'b1 || sweep_idx !== 4'd7) begin
      failures++;
      $display("FAIL mid_reach_idx7: valid=%b idx=%0d, want 1 7", sweep_valid, sweep_idx);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || sweep_valid !== 1'b0 || done !== 1'b0 || ones_count !== 5'd0 ||
        sweep_idx !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs: busy=%b sv=%b done=%b cnt=%0d idx=%0d, want 0 0 0 0 0",
               busy, sweep_valid, done, ones_count, sweep_idx);
    end
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1 || busy === 1'b1) done_seen++;
      step();
    end
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL mid_no_done: active cycles=%0d, want 0", done_seen);
    end
    run_sweep("sweep_after_mid_reset", init_tbl, 8, -1, 1'b0);
  endtask

  task automatic test_same_cycle();
    pulse_reset();
    eval_valid = 1'b1;
    eval_in    = 4'd3;
    cfg_we     = 1'b1;
    cfg_addr   = 4'd3;
    cfg_bit    = 1'b0;
    step();
    cfg_we = 1'b0;
    checks++;
    if (eval_out_valid !== 1'b1 || eval_out !== 1'b1) begin
      failures++;
      $display("FAIL same_cycle_old: valid=%b out=%b, want 1 1", eval_out_valid, eval_out);
    end
    step();
    eval_valid = 1'b0;
    checks++;
    if (eval_out_valid !== 1'b1 || eval_out !== 1'b0) begin
      failures++;
      $display("FAIL next_cycle_new: valid=%b out=%b, want 1 0", eval_out_valid, eval_out);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    init_tbl   = 16'hAC3C;
    rst        = 1'b1;
    cfg_we     = 1'b0;
    cfg_addr   = 4'd0;
    cfg_bit    = 1'b0;
    eval_valid = 1'b0;
    eval_in    = 4'd0;
    start      = 1'b0;
    #1;
    test_reset();
    test_sweep_init();
    test_eval_all();
    test_cfg_writes();
    test_busy_ignore();
    test_reset_mid();
    test_same_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lut_sweep_unit.md
# lut_sweep_unit

Parametrised, programmable N-input boolean function unit for the R01 combinational exercises. A 2^N-entry truth-table register replaces the hard-wired sum-of-products gates. The unit evaluates single input vectors with a registered output, and its sweep engine walks all 2^N input combinations, streams each result and counts the true minterms. Benches and later exercises use it as a reusable truth-table generator/checker.

## Interface
Parameters:
- N, 4, number of function inputs (2..8)
- INIT, 16'hAC3C, reset truth table (2^N bits), bit i = f(input vector i), MSB input = a; default encodes s = (~b&c) | (~a&b&~c) | (a&b&d)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  write one truth-table bit
- cfg_addr  in  N  minterm index to write
- cfg_bit  in  1  value written
- eval_valid  in  1  evaluate request
- eval_in  in  N  input vector {a,b,c,d,...}, MSB first
- eval_out_valid  out  1  registered result valid
- eval_out  out  1  f(eval_in)
- start  in  1  begin exhaustive sweep
- busy  out  1  sweep in progress
- sweep_valid  out  1  sweep_idx/sweep_val valid this cycle
- sweep_idx  out  N  current minterm index
- sweep_val  out  1  table bit at sweep_idx
- done  out  1  one-cycle pulse, sweep finished
- ones_count  out  N+1  number of 1 entries found by last sweep

## Operation
- Table: 2^N flops, loaded from INIT on rst.
- Config: cfg_we=1 writes cfg_bit to table[cfg_addr] at the edge. The write is ignored while busy=1.
- Evaluate: eval_valid=1 registers eval_out=table[eval_in] and eval_out_valid=1 for one cycle. Otherwise eval_out_valid=0 and eval_out holds its value. Eval is legal in any state, including during a sweep.
- Read-before-write: eval and cfg to the same index in the same cycle returns the old bit.
- FSM states IDLE, SWEEP, DONE:
  - IDLE: start=1 moves to SWEEP, clears ones_count to 0 and sets index 0.
  - SWEEP: each cycle outputs sweep_valid=1, sweep_idx=index, sweep_val=table[index], and adds sweep_val to ones_count. At index 2^N-1 it moves to DONE; otherwise index+1.
  - DONE: done=1 for one cycle, then IDLE.
- start is ignored unless the state is IDLE. A start in the DONE cycle is also ignored.
- ones_count is N+1 bits wide so that the all-ones table (2^N) never wraps. It holds its value from DONE until the next accepted start.
- Reset mid-sweep: next state IDLE, table reloaded to INIT, all outputs at their reset values.

## Timing
- Reset values: eval_out_valid=0, eval_out=0, busy=0, sweep_valid=0, sweep_idx=0, sweep_val=0, done=0, ones_count=0.
- Eval latency is 1 cycle: a request at edge k gives a valid result after edge k. Back-to-back requests give one result per cycle.
- Sweep:
  - start sampled at edge k.
  - sweep_valid is high for cycles k+1 .. k+2^N, with idx 0 .. 2^N-1 in order.
  - done is high in cycle k+2^N+1, with ones_count final in that same cycle.
  - busy is high from k+1 through the done cycle inclusive.
  - Total sweep length is 2^N+1 cycles.
- A cfg write accepted at edge k is visible to an eval or sweep read at edge k+1.

## Test plan
- Reset, then sweep with INIT=16'hAC3C: stream is 0,0,1,1,1,1,0,0,0,0,1,1,0,1,0,1 for idx 0..15; done in cycle 17 after start; ones_count=8.
- Eval all 16 vectors back-to-back after reset: eval_out matches the stream above, 1-cycle latency, eval_out_valid high for 16 consecutive cycles.
- Write table[12]=1 and table[2]=0, then sweep: idx12 val=1, idx2 val=0, ones_count=8. Write all zeros: ones_count=0. Write all ones: ones_count=16 (no wrap).
- During a sweep, pulse start and cfg_we (addr 0, bit 1): both are ignored. The stream and ones_count are unchanged and table[0] stays 0 afterwards.
- Assert rst at sweep idx 7: the next cycle has busy=0 and sweep_valid=0, no done pulse, and the table is back to AC3C.
- Same-cycle eval and cfg at addr 3 (old 1, write 0): eval_out=1. An eval one cycle later returns 0.
